rr_bus_arbiter_8: RTL

//  Round-robin arbiter sharing one 64-bit bus among 8 requesters. It drives the

---
 rtl/rr_bus_arbiter_8.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rr_bus_arbiter_8.sv
// Round-robin arbiter that shares one 64-bit bus among 8 requesters.
// The winning word goes through an internal 8:1 mux into a single-entry valid/ready output stage.

module mux_8x1 #(
    parameter int W = 64
) (
    input  logic [2:0]   sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [W-1:0] in4,
    input  logic [W-1:0] in5,
    input  logic [W-1:0] in6,
    input  logic [W-1:0] in7,
    output logic [W-1:0] out
);
    always_comb begin
        case (sel)
            3'd0:    out = in0;
            3'd1:    out = in1;
            3'd2:    out = in2;
            3'd3:    out = in3;
            3'd4:    out = in4;
            3'd5:    out = in5;
            3'd6:    out = in6;
            default: out = in7;
        endcase
    end
endmodule

module rr_bus_arbiter_8 #(
    parameter int          CNT_W   = 16,
    parameter logic [2:0]  RST_PTR = 3'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       req,
    input  logic [63:0]      d0,
    input  logic [63:0]      d1,
    input  logic [63:0]      d2,
    input  logic [63:0]      d3,
    input  logic [63:0]      d4,
    input  logic [63:0]      d5,
    input  logic [63:0]      d6,
    input  logic [63:0]      d7,
    output logic [7:0]       gnt,
    output logic [2:0]       mux_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [2:0]       out_src,
    output logic [CNT_W-1:0] xfer_count
);
    typedef enum logic {IDLE, FULL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [2:0]       ptr_reg;
    logic [7:0]       rot_req;
    logic [2:0]       offset;
    logic [2:0]       winner;
    logic             accept;
    logic [63:0]      mux_out;
    logic [63:0]      out_data_reg;
    logic [2:0]       out_src_reg;
    logic [CNT_W-1:0] xfer_count_reg;

    // rot_req[k] is the request sitting k places after the priority pointer
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + 3'(gi)];
        end
    endgenerate

    always_comb begin
        offset = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rot_req[k]) begin
                offset = 3'(k);
            end
        end
    end

    // With no request the offset stays 0, so the select rests on the pointer
    assign winner  = ptr_reg + offset;
    assign mux_sel = winner;
    assign accept  = (|req) && (!out_valid || out_ready) && !reset;
    assign gnt     = accept ? (8'd1 << winner) : 8'd0;

    mux_8x1 #(.W(64)) u_mux (
        .sel (winner),
        .in0 (d0),
        .in1 (d1),
        .in2 (d2),
        .in3 (d3),
        .in4 (d4),
        .in5 (d5),
        .in6 (d6),
        .in7 (d7),
        .out (mux_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = FULL;
            FULL:    if (out_ready && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_reg == FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_reg   <= 64'd0;
            out_src_reg    <= 3'd0;
            ptr_reg        <= RST_PTR;
            xfer_count_reg <= '0;
        end else begin
            if (accept) begin
                out_data_reg <= mux_out;
                out_src_reg  <= winner;
                ptr_reg      <= winner + 3'd1;
            end
            if (out_valid && out_ready && (xfer_count_reg != CNT_MAX)) begin
                xfer_count_reg <= xfer_count_reg + 1'b1;
            end
        end
    end

    assign out_data   = out_data_reg;
    assign out_src    = out_src_reg;
    assign xfer_count = xfer_count_reg;

endmodule
